// File: rtl/netlist_truth_table_reader.sv
// Exhaustive-sweep characterisation driver: steps a combinational netlist through every
// input vector and packs its 1-bit responses into a truth-table byte stream.
// Optional CRC-16 signature of the response stream is enabled with `define TT_READER_SIG_EN.
module netlist_truth_table_reader #(
  parameter int N_IN   = 7,
  parameter int SETTLE = 2,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [N_IN-1:0]   stim,
  input  logic              resp,
  output logic [OUT_W-1:0]  tt_data,
  output logic              tt_valid,
  input  logic              tt_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int BW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [N_IN-1:0] LAST_VEC    = {N_IN{1'b1}};
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [BW-1:0]   BIT_LAST    = BW'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [OUT_W-1:0]  shift_q, shift_d;
  logic              last_q, last_d;
`ifdef TT_READER_SIG_EN
  logic [15:0]       sig_q, sig_d;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stim_q   <= '0;
      settle_q <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      last_q   <= 1'b0;
`ifdef TT_READER_SIG_EN
      sig_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      last_q   <= last_d;
`ifdef TT_READER_SIG_EN
      sig_q    <= sig_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    last_d   = last_q;
`ifdef TT_READER_SIG_EN
    sig_d    = sig_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          stim_d   = '0;
          settle_d = '0;
          bit_d    = '0;
          shift_d  = '0;
          last_d   = 1'b0;
`ifdef TT_READER_SIG_EN
          sig_d    = '0;
`endif
        end
      end
      DRIVE: begin
        // Response is sampled only on the final settle cycle of each vector.
        if (settle_q == SETTLE_LAST) begin
          settle_d       = '0;
          shift_d[bit_q] = resp;
`ifdef TT_READER_SIG_EN
          sig_d = {sig_q[14:0], 1'b0} ^ ((sig_q[15] ^ resp) ? 16'h1021 : 16'h0000);
`endif
          if (bit_q == BIT_LAST || stim_q == LAST_VEC) begin
            state_d = EMIT;
            bit_d   = '0;
            last_d  = (stim_q == LAST_VEC);
          end else begin
            stim_d = stim_q + 1'b1;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      EMIT: begin
        if (tt_ready) begin
          shift_d = '0;
          if (last_q) begin
            state_d = DONE;
            stim_d  = '0;
          end else begin
            state_d = DRIVE;
            stim_d  = stim_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stim     = stim_q;
  assign tt_data  = shift_q;
  assign tt_valid = (state_q == EMIT);
  assign busy     = (state_q == DRIVE) || (state_q == EMIT);
  assign done     = (state_q == DONE);
`ifdef TT_READER_SIG_EN
  assign signature = sig_q;
`else
  assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_netlist_truth_table_reader.sv
// Table-driven bench for netlist_truth_table_reader: full sweeps with several response
// functions, backpressure, a mid-sweep reset and an ignored restart request.
module tb_netlist_truth_table_reader;

  localparam int N_IN    = 7;
  localparam int SETTLE  = 2;
  localparam int OUT_W   = 8;
  localparam int NWORDS  = 16;
  localparam int LATENCY = 273;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic [N_IN-1:0] stim;
  logic            resp;
  logic [OUT_W-1:0] ttData;
  logic            ttValid;
  logic            ttReady;
  logic            busy;
  logic            done;
  logic [15:0]     signature;
  int              respMode;

  netlist_truth_table_reader #(.N_IN(N_IN), .SETTLE(SETTLE), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .resp(resp),
    .tt_data(ttData), .tt_valid(ttValid), .tt_ready(ttReady),
    .busy(busy), .done(done), .signature(signature)
  );

  always #5 clk = ~clk;

  // Combinational netlist stand-in selected per test row.
  always_comb begin
    case (respMode)
      1:       resp = stim[0];
      2:       resp = &stim[2:0];
      default: resp = 1'b0;
    endcase
  end

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic respOf(input int mode, input int v);
    logic [N_IN-1:0] s;
    s = N_IN'(v);
    case (mode)
      1:       return s[0];
      2:       return &s[2:0];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] crcModel(input int mode);
    logic [15:0] c;
    logic        fb;
    c = 16'h0000;
    for (int v = 0; v < (1 << N_IN); v++) begin
      fb = c[15] ^ respOf(mode, v);
      c  = c << 1;
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  typedef struct {
    int         respMode;
    int         stallWord;
    int         restartAt;
    logic [7:0] expWord;
    int         expDoneCyc;
  } vec_t;

  vec_t vecs[4];

  logic [7:0]      gotWords[$];
  int              doneCount, doneCyc, busyErr, stimErr, stallErr, stallSeen, maxStim;
  logic [15:0]     sigAtDone;
  logic [N_IN-1:0] stimAtDone;

  task automatic applyStimulus(input int mode, input int stallWord, input int restartAt,
                               input int abortAt, output bit aborted);
    int              prevStim, runLen;
    bit              pulsed;
    logic [7:0]      heldData;
    logic [N_IN-1:0] heldStim;
    aborted = 1'b0;
    respMode = mode;
    gotWords.delete();
    doneCount = 0; doneCyc = -1; busyErr = 0; stimErr = 0; stallErr = 0; stallSeen = 0;
    maxStim = 0; prevStim = 0; runLen = 0; pulsed = 1'b0; heldData = '0; heldStim = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (abortAt >= 0 && int'(stim) == abortAt) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        aborted = 1'b1;
        return;
      end
      ttReady = 1'b1;
      if (ttValid && stallWord >= 0 && gotWords.size() == stallWord && stallSeen < 5) begin
        if (stallSeen == 0) begin
          heldData = ttData;
          heldStim = stim;
        end else if (ttData !== heldData || stim !== heldStim) begin
          stallErr++;
        end
        ttReady = 1'b0;
        stallSeen++;
      end
      if (ttValid && ttReady) begin
        if (stallWord >= 0 && gotWords.size() == stallWord && ttData !== heldData) stallErr++;
        gotWords.push_back(ttData);
      end
      if (doneCyc < 0) begin
        if (done) begin
          doneCount++;
          doneCyc    = cyc;
          stimAtDone = stim;
          sigAtDone  = signature;
          if (busy) busyErr++;
          start = (restartAt >= 0);
        end else begin
          if (!busy) busyErr++;
          if (cyc == 0) begin
            if (stim !== '0) stimErr++;
            prevStim = int'(stim);
            runLen   = 1;
          end else if (int'(stim) == prevStim) begin
            runLen++;
          end else begin
            if (int'(stim) != prevStim + 1 || runLen < SETTLE) stimErr++;
            prevStim = int'(stim);
            runLen   = 1;
          end
          maxStim = prevStim;
          start = (restartAt >= 0 && int'(stim) == restartAt && !pulsed);
          if (start) pulsed = 1'b1;
        end
      end else begin
        start = 1'b0;
        if (done) doneCount++;
        if (busy) busyErr++;
        if (cyc >= doneCyc + 4) break;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic checkSweep(input string tag, input int mode, input logic [7:0] expWord,
                            input int expDoneCyc, input bit stalled);
    logic [15:0] expSig;
`ifdef TT_READER_SIG_EN
    expSig = crcModel(mode);
`else
    expSig = 16'h0000;
`endif
    checkOutput({tag, ".wordCount"}, gotWords.size(), NWORDS);
    foreach (gotWords[i]) checkOutput($sformatf("%s.word%0d", tag, i), gotWords[i], expWord);
    checkOutput({tag, ".doneCount"}, doneCount, 1);
    checkOutput({tag, ".doneLatency"}, doneCyc + 1, expDoneCyc);
    checkOutput({tag, ".busyProfile"}, busyErr, 0);
    checkOutput({tag, ".stimStepping"}, stimErr, 0);
    checkOutput({tag, ".stimMax"}, maxStim, (1 << N_IN) - 1);
    checkOutput({tag, ".stimAtDone"}, stimAtDone, 0);
    checkOutput({tag, ".signature"}, sigAtDone, expSig);
    checkOutput({tag, ".signatureHeld"}, signature, expSig);
    if (stalled) begin
      checkOutput({tag, ".stallCycles"}, stallSeen, 5);
      checkOutput({tag, ".stallStable"}, stallErr, 0);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, ".stim"}, stim, 0);
    checkOutput({tag, ".ttData"}, ttData, 0);
    checkOutput({tag, ".ttValid"}, ttValid, 0);
    checkOutput({tag, ".busy"}, busy, 0);
    checkOutput({tag, ".done"}, done, 0);
    checkOutput({tag, ".signature"}, signature, 0);
  endtask

  initial begin
    bit aborted;
    vecs[0] = '{respMode: 0, stallWord: -1, restartAt: -1, expWord: 8'h00, expDoneCyc: LATENCY};
    vecs[1] = '{respMode: 1, stallWord: -1, restartAt: -1, expWord: 8'hAA, expDoneCyc: LATENCY};
    vecs[2] = '{respMode: 2, stallWord: -1, restartAt: -1, expWord: 8'h80, expDoneCyc: LATENCY};
    vecs[3] = '{respMode: 1, stallWord:  3, restartAt: 10, expWord: 8'hAA, expDoneCyc: LATENCY + 5};

    rst_n = 1'b0; start = 1'b0; ttReady = 1'b1; respMode = 0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 4; r++) begin
      applyStimulus(vecs[r].respMode, vecs[r].stallWord, vecs[r].restartAt, -1, aborted);
      checkSweep($sformatf("row%0d", r), vecs[r].respMode, vecs[r].expWord,
                 vecs[r].expDoneCyc, vecs[r].stallWord >= 0);
      checkOutput($sformatf("row%0d.idleAfterDone", r), busy, 0);
      repeat (2) @(negedge clk);
    end

    applyStimulus(1, -1, -1, 50, aborted);
    checkOutput("abort.reached", aborted, 1);
    checkIdleOutputs("abort");
    @(negedge clk);
    checkOutput("abort.staysIdle", busy, 0);
    applyStimulus(1, -1, -1, -1, aborted);
    checkSweep("afterAbort", 1, 8'hAA, LATENCY, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
